// File: rtl/spi_readout_pkg.sv
// spi_readout_pkg: types and constants shared by the SPI readout transmit path.
//   state_t      - transmit FSM state encoding
//   HDR_MARKER   - top nibble of the per-channel header word
//   FRAME_CNT_W  - width of the wrapping frame counter
//   idx_w()      - index width for a table of n entries (never below 1)
package spi_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    NEXT,
    DONE,
    HDR
  } state_t;

  localparam logic [3:0] HDR_MARKER  = 4'hA;
  localparam int         FRAME_CNT_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI clock divider. Each SCLK half-period lasts SCLK_DIV clk cycles.
// While en is low the divider is held in its low phase with the count cleared,
// so the first half-period after enabling is always a full low phase.
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   en         in   run the divider
//   sclk       out  registered SCLK level
//   rise_tick  out  high in the cycle whose closing edge drives sclk 0->1
//   fall_tick  out  high in the cycle whose closing edge drives sclk 1->0
module spi_sclk_gen
  import spi_readout_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int               CNT_W    = idx_w(SCLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase_end;

  assign phase_end = en && (cnt == CNT_LAST);
  assign rise_tick = phase_end && !sclk;
  assign fall_tick = phase_end && sclk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (phase_end) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_readout_tx.sv
// spi_readout_tx: reads every channel's buffered samples (channel-major) on a
// rising edge of ZYNQ_RD_EN and shifts them MSB first over a mode-0 SPI link.
// Optional feature macro: SPI_RD_HDR_EN - prefix each channel with a header word
// {HDR_MARKER, chn[3:0], frame_cnt[7:0]} in the top 16 bits (needs WORD_W >= 16).
// Ports:
//   clk, reset (async, active-low)
//   ZYNQ_RD_EN   in   frame request level; rising edge starts, low aborts
//   buf_rd_req   out  one-cycle sample-buffer read strobe
//   buf_chn      out  channel index of the read
//   buf_addr     out  word index of the read
//   buf_data     in   read data, valid one cycle after buf_rd_req
//   SPI_SCLK, SPI_CS_N, SPI_MOSI  out  SPI link (SCLK idles low)
//   SPI_complete out  one-cycle end-of-frame pulse, coincident with CS_N rising
//   busy         out  FSM not in IDLE
module spi_readout_tx
  import spi_readout_pkg::*;
#(
  parameter int NUM_CHN       = 4,
  parameter int WORDS_PER_CHN = 8,
  parameter int WORD_W        = 16,
  parameter int SCLK_DIV      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ZYNQ_RD_EN,
  output logic                             buf_rd_req,
  output logic [idx_w(NUM_CHN)-1:0]        buf_chn,
  output logic [idx_w(WORDS_PER_CHN)-1:0]  buf_addr,
  input  logic [WORD_W-1:0]                buf_data,
  output logic                             SPI_SCLK,
  output logic                             SPI_CS_N,
  output logic                             SPI_MOSI,
  output logic                             SPI_complete,
  output logic                             busy
);

  localparam int                CHN_W     = idx_w(NUM_CHN);
  localparam int                ADDR_W    = idx_w(WORDS_PER_CHN);
  localparam int                BIT_W     = $clog2(WORD_W + 1);
  localparam logic [CHN_W-1:0]  CHN_LAST  = CHN_W'(NUM_CHN - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS_PER_CHN - 1);
  localparam logic [BIT_W-1:0]  BITS_WORD = BIT_W'(WORD_W);

  state_t                 state;
  logic                   rd_en_q;
  logic                   start_q;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [WORD_W-1:0]      shreg;
  logic [WORD_W-1:0]      shreg_nxt;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   abort;
  logic                   last_word;
  logic                   sclk_en;
  logic                   rise_tick;
  logic                   fall_tick;

`ifdef SPI_RD_HDR_EN
  logic in_hdr;  // the word currently in shreg is a channel header

  function automatic logic [WORD_W-1:0] hdr_word(input logic [CHN_W-1:0] c,
                                                 input logic [FRAME_CNT_W-1:0] fc);
    logic [WORD_W-1:0] w;
    w = '0;
    w[WORD_W-1 -: 16] = {HDR_MARKER, 4'(c), fc};
    return w;
  endfunction

  assign last_word = !in_hdr && (buf_chn == CHN_LAST) && (buf_addr == ADDR_LAST);
`else
  assign last_word = (buf_chn == CHN_LAST) && (buf_addr == ADDR_LAST);
`endif

  // A dropped request is acted on at the very next edge, including the divider,
  // so SCLK is already low in the cycle after ZYNQ_RD_EN is seen low.
  assign abort     = !ZYNQ_RD_EN && (state != IDLE) && (state != DONE);
  assign sclk_en   = (state == SHIFT) && !abort;
  assign shreg_nxt = shreg << 1;

  spi_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .en        (sclk_en),
    .sclk      (SPI_SCLK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rd_en_q      <= 1'b0;
      start_q      <= 1'b0;
      frame_cnt    <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      buf_rd_req   <= 1'b0;
      buf_chn      <= '0;
      buf_addr     <= '0;
      SPI_CS_N     <= 1'b1;
      SPI_MOSI     <= 1'b0;
      SPI_complete <= 1'b0;
      busy         <= 1'b0;
`ifdef SPI_RD_HDR_EN
      in_hdr       <= 1'b0;
`endif
    end else begin
      rd_en_q      <= ZYNQ_RD_EN;
      // Start is registered once, so the frame opens one edge after the
      // rising request is first sampled; a held-high level never re-arms it.
      start_q      <= ZYNQ_RD_EN && !rd_en_q && (state == IDLE);
      buf_rd_req   <= 1'b0;
      SPI_complete <= 1'b0;

      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        SPI_CS_N <= 1'b1;
        SPI_MOSI <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_q) begin
              SPI_CS_N <= 1'b0;
              busy     <= 1'b1;
              buf_chn  <= '0;
              buf_addr <= '0;
`ifdef SPI_RD_HDR_EN
              state      <= HDR;
`else
              buf_rd_req <= 1'b1;
              state      <= FETCH;
`endif
            end
          end

          FETCH: state <= LOAD;

          LOAD: begin
            shreg    <= buf_data;
            SPI_MOSI <= buf_data[WORD_W-1];
            bit_cnt  <= '0;
`ifdef SPI_RD_HDR_EN
            in_hdr   <= 1'b0;
`endif
            state    <= SHIFT;
          end

`ifdef SPI_RD_HDR_EN
          HDR: begin
            shreg    <= hdr_word(buf_chn, frame_cnt);
            SPI_MOSI <= HDR_MARKER[3];
            bit_cnt  <= '0;
            in_hdr   <= 1'b1;
            state    <= SHIFT;
          end
`endif

          // Bits are counted on SCLK rises (Zynq sample points); the word ends
          // on the falling edge that closes its last high phase.
          SHIFT: begin
            if (rise_tick) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall_tick) begin
              shreg    <= shreg_nxt;
              SPI_MOSI <= shreg_nxt[WORD_W-1];
              if (bit_cnt == BITS_WORD) begin
                state <= last_word ? DONE : NEXT;
              end
            end
          end

          NEXT: begin
`ifdef SPI_RD_HDR_EN
            if (in_hdr) begin
              // header done: fetch this channel's first sample, addr already 0
              buf_rd_req <= 1'b1;
              state      <= FETCH;
            end else if (buf_addr == ADDR_LAST) begin
              buf_addr <= '0;
              buf_chn  <= buf_chn + 1'b1;
              state    <= HDR;
            end else begin
              buf_addr   <= buf_addr + 1'b1;
              buf_rd_req <= 1'b1;
              state      <= FETCH;
            end
`else
            if (buf_addr == ADDR_LAST) begin
              buf_addr <= '0;
              buf_chn  <= buf_chn + 1'b1;
            end else begin
              buf_addr <= buf_addr + 1'b1;
            end
            buf_rd_req <= 1'b1;
            state      <= FETCH;
`endif
          end

          DONE: begin
            SPI_CS_N     <= 1'b1;
            SPI_complete <= 1'b1;
            frame_cnt    <= frame_cnt + 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_readout_tx.sv
// tb_spi_readout_tx: directed sequence with randomized buffer contents for two
// spi_readout_tx instances (2 channels x 2 words x 16 bits; SCLK_DIV 2 and 1).
// Expected MOSI words come from a channel-major word list built from the
// buffer tables; the buffer model only presents data in the single cycle
// after a read strobe and drives random garbage otherwise.
`timescale 1ns/1ps
module tb_spi_readout_tx;

  localparam int NCH = 2;
  localparam int NW  = 2;
  localparam int WW  = 16;
`ifdef SPI_RD_HDR_EN
  localparam bit HDR_ON = 1'b1;
  localparam int WPC    = NW + 1;
`else
  localparam bit HDR_ON = 1'b0;
  localparam int WPC    = NW;
`endif
  localparam int FRAME_WORDS = NCH * WPC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        rd_en_a, req_a, sclk_a, cs_a, mosi_a, cmpl_a, busy_a;
  logic [0:0]  chn_a, addr_a;
  logic [15:0] data_a = '0;
  logic        rd_en_b, req_b, sclk_b, cs_b, mosi_b, cmpl_b, busy_b;
  logic [0:0]  chn_b, addr_b;
  logic [15:0] data_b = '0;

  logic [15:0] mem_a [NCH][NW];
  logic [15:0] mem_b [NCH][NW];

  int total = 0;
  int bad   = 0;

  spi_readout_tx #(.NUM_CHN(NCH), .WORDS_PER_CHN(NW), .WORD_W(WW), .SCLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .ZYNQ_RD_EN(rd_en_a), .buf_rd_req(req_a),
    .buf_chn(chn_a), .buf_addr(addr_a), .buf_data(data_a), .SPI_SCLK(sclk_a),
    .SPI_CS_N(cs_a), .SPI_MOSI(mosi_a), .SPI_complete(cmpl_a), .busy(busy_a));

  spi_readout_tx #(.NUM_CHN(NCH), .WORDS_PER_CHN(NW), .WORD_W(WW), .SCLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .ZYNQ_RD_EN(rd_en_b), .buf_rd_req(req_b),
    .buf_chn(chn_b), .buf_addr(addr_b), .buf_data(data_b), .SPI_SCLK(sclk_b),
    .SPI_CS_N(cs_b), .SPI_MOSI(mosi_b), .SPI_complete(cmpl_b), .busy(busy_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // buffer models: data valid only in the cycle after the read strobe
  logic       req_a_n = 1'b0, req_b_n = 1'b0;
  logic [0:0] chn_a_n = '0, addr_a_n = '0, chn_b_n = '0, addr_b_n = '0;
  always @(negedge clk) begin
    req_a_n = req_a; chn_a_n = chn_a; addr_a_n = addr_a;
    req_b_n = req_b; chn_b_n = chn_b; addr_b_n = addr_b;
  end
  always @(posedge clk) begin
    #1;
    data_a = req_a_n ? mem_a[chn_a_n][addr_a_n] : 16'($urandom);
    data_b = req_b_n ? mem_b[chn_b_n][addr_b_n] : 16'($urandom);
  end

  // link monitors
  logic bits_a[$];
  logic bits_b[$];
  int   cmpl_cnt_a = 0, cmpl_cnt_b = 0;
  int   reads_b [NCH][NW];
  logic cs_prev_a = 1'b1, cs_prev_b = 1'b1, req_prev_a = 1'b0, req_prev_b = 1'b0;

  always @(posedge sclk_a) bits_a.push_back(mosi_a);
  always @(posedge sclk_b) bits_b.push_back(mosi_b);

  always @(negedge clk) begin
    if (cmpl_a) begin
      cmpl_cnt_a++;
      check("cmpl_with_cs_rise_a", {cs_prev_a, cs_a}, 2'b01);
    end
    if (cmpl_b) begin
      cmpl_cnt_b++;
      check("cmpl_with_cs_rise_b", {cs_prev_b, cs_b}, 2'b01);
    end
    if (req_a) check("rdreq_one_cycle_a", req_prev_a, 1'b0);
    if (req_b) begin
      check("rdreq_one_cycle_b", req_prev_b, 1'b0);
      reads_b[chn_b][addr_b]++;
    end
    cs_prev_a = cs_a; cs_prev_b = cs_b;
    req_prev_a = req_a; req_prev_b = req_b;
  end

  // reference: channel-major word list for one frame
  logic [15:0] exp_q[$];
  task automatic build_exp(input bit use_b, input int fc);
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      if (HDR_ON) exp_q.push_back({4'hA, 4'(c), 8'(fc)});
      for (int a = 0; a < NW; a++) exp_q.push_back(use_b ? mem_b[c][a] : mem_a[c][a]);
    end
  endtask

  function automatic logic [15:0] word_at(input bit use_b, input int i);
    logic [15:0] w;
    int          idx;
    int          nb;
    w  = '0;
    nb = use_b ? bits_b.size() : bits_a.size();
    for (int k = 0; k < WW; k++) begin
      idx = i * WW + k;
      w = {w[14:0], (idx < nb) ? (use_b ? bits_b[idx] : bits_a[idx]) : 1'b0};
    end
    return w;
  endfunction

  task automatic check_stream(input string tag, input bit use_b);
    check({tag, "_sclk_rises"}, use_b ? bits_b.size() : bits_a.size(), FRAME_WORDS * WW);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), word_at(use_b, i), exp_q[i]);
  endtask

  task automatic wait_cmpl(input bit use_b, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (use_b ? cmpl_b : cmpl_a) seen = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    cs_a,   1'b1);
    check({tag, "_sclk"},  sclk_a, 1'b0);
    check({tag, "_mosi"},  mosi_a, 1'b0);
    check({tag, "_req"},   req_a,  1'b0);
    check({tag, "_chn"},   chn_a,  1'b0);
    check({tag, "_addr"},  addr_a, 1'b0);
    check({tag, "_cmpl"},  cmpl_a, 1'b0);
    check({tag, "_busy"},  busy_a, 1'b0);
  endtask

  initial begin
    bit seen;
    int c0, lowcnt, n, fc_a;
    fc_a    = 0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    reset   = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < NW; a++) begin
        mem_a[c][a]   = {4'(c), 4'(a), 8'hA5};
        mem_b[c][a]   = 16'($urandom);
        reads_b[c][a] = 0;
      end
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // frame 1: known pattern
    bits_a.delete(); c0 = cmpl_cnt_a;
    rd_en_a = 1'b1;
    @(negedge clk);
    check("edge0_cs", cs_a, 1'b1);
    check("edge0_req", req_a, 1'b0);
    @(negedge clk);
    check("edge1_req", req_a, HDR_ON ? 1'b0 : 1'b1);
    check("edge1_cs", cs_a, 1'b0);
    check("edge1_busy", busy_a, 1'b1);
    wait_cmpl(1'b0, 3000, seen);
    check("f1_complete_seen", seen, 1'b1);
    check("f1_cs_at_cmpl", cs_a, 1'b1);
    build_exp(1'b0, fc_a); fc_a++;
    check_stream("f1", 1'b0);

    // level held high: no retrigger
    lowcnt = 0;
    repeat (500) begin @(negedge clk); if (!cs_a) lowcnt++; end
    check("held_high_cs_low_cycles", lowcnt, 0);
    check("held_high_cmpl_count", cmpl_cnt_a - c0, 1);

    // abort after 20th SCLK rise
    rd_en_a = 1'b0;
    repeat (5) @(negedge clk);
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < NW; a++) mem_a[c][a] = 16'($urandom);
    bits_a.delete(); c0 = cmpl_cnt_a;
    rd_en_a = 1'b1;
    n = 0;
    while (bits_a.size() < 20 && n < 2000) begin @(negedge clk); n++; end
    check("abort_reached_20_rises", bits_a.size(), 20);
    rd_en_a = 1'b0;
    @(negedge clk);
    check("abort_cs", cs_a, 1'b1);
    check("abort_sclk", sclk_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    repeat (300) @(negedge clk);
    check("abort_no_cmpl", cmpl_cnt_a - c0, 0);
    check("abort_frame_cnt", dut_a.frame_cnt, fc_a);

    // restart: full frame from chn 0 addr 0, controller drops request after cmpl
    bits_a.delete(); c0 = cmpl_cnt_a;
    rd_en_a = 1'b1;
    @(negedge clk); @(negedge clk);
    check("restart_req", req_a, HDR_ON ? 1'b0 : 1'b1);
    check("restart_chn", chn_a, 1'b0);
    check("restart_addr", addr_a, 1'b0);
    wait_cmpl(1'b0, 3000, seen);
    rd_en_a = 1'b0;
    check("f2_complete_seen", seen, 1'b1);
    build_exp(1'b0, fc_a); fc_a++;
    check_stream("f2", 1'b0);
    lowcnt = 0;
    repeat (50) begin @(negedge clk); if (!cs_a) lowcnt++; end
    check("fall_no_restart", lowcnt, 0);
    check("f2_cmpl_count", cmpl_cnt_a - c0, 1);

    // third completed frame
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < NW; a++) mem_a[c][a] = 16'($urandom);
    bits_a.delete();
    rd_en_a = 1'b1;
    wait_cmpl(1'b0, 3000, seen);
    rd_en_a = 1'b0;
    check("f3_complete_seen", seen, 1'b1);
    build_exp(1'b0, fc_a); fc_a++;
    check_stream("f3", 1'b0);
`ifdef SPI_RD_HDR_EN
    check("f3_chn1_header", word_at(1'b0, WPC), 16'hA102);
`endif
    repeat (5) @(negedge clk);

    // asynchronous reset mid-word
    rd_en_a = 1'b1;
    n = 0;
    while (bits_a.size() < FRAME_WORDS * WW + 5 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("async_rst_frame_cnt", dut_a.frame_cnt, 0);
    rd_en_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // DIV=1 instance: each word read once, 1-cycle read latency
    bits_b.delete(); c0 = cmpl_cnt_b;
    rd_en_b = 1'b1;
    wait_cmpl(1'b1, 3000, seen);
    rd_en_b = 1'b0;
    check("b_complete_seen", seen, 1'b1);
    build_exp(1'b1, 0);
    check_stream("b", 1'b1);
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < NW; a++)
        check($sformatf("b_reads_c%0d_a%0d", c, a), reads_b[c][a], 1);
    repeat (10) @(negedge clk);
    check("b_cmpl_count", cmpl_cnt_b - c0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_readout_tx.md
# spi_readout_tx

Downstream SPI transmit stage of the multi-channel readout path. On a rising edge of `ZYNQ_RD_EN` it reads every channel's buffered samples in channel-major order and shifts them to the Zynq over a mode-0 SPI link, using the local `clk`. When the frame is finished it pulses `SPI_complete`, which returns the readout controller to IDLE.

## Interface
- `NUM_CHN`, default 4: number of channels; must be 1–16.
- `WORDS_PER_CHN`, default 8: samples per channel per frame; must be ≥1.
- `WORD_W`, default 16: sample width in bits; must be ≥16 when the header feature is compiled in.
- `SCLK_DIV`, default 4: length of each SCLK half-period in `clk` cycles; must be ≥1.

- `clk`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ZYNQ_RD_EN`  in  1  readout request from the readout controller; a level held high for the whole frame.
- `buf_rd_req`  out  1  one-cycle sample-buffer read strobe.
- `buf_chn`  out  max(1,$clog2(NUM_CHN))  channel index of the read.
- `buf_addr`  out  max(1,$clog2(WORDS_PER_CHN))  word index of the read.
- `buf_data`  in  WORD_W  buffer read data; valid exactly 1 cycle after `buf_rd_req`.
- `SPI_SCLK`  out  1  SPI clock; idles low.
- `SPI_CS_N`  out  1  chip select, active low.
- `SPI_MOSI`  out  1  serial data, MSB first.
- `SPI_complete`  out  1  one-cycle pulse marking the end of a full frame.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset values:
  - outputs: `SPI_CS_N`=1, `SPI_SCLK`=0, `SPI_MOSI`=0, `buf_rd_req`=0, `buf_chn`=0, `buf_addr`=0, `SPI_complete`=0, `busy`=0;
  - internal: `frame_cnt`=0, and the registered `ZYNQ_RD_EN` copy = 0.
- Start condition: a 0→1 transition of `ZYNQ_RD_EN`, detected against its registered copy, while in IDLE.
  - A level that stays high does not retrigger.
- State machine:
  - **IDLE**: on a start, assert `buf_rd_req`, drive `SPI_CS_N` low and set chn/addr to 0; go to FETCH.
  - **FETCH**: one cycle waiting for `buf_data`; go to LOAD.
  - **LOAD**: capture `buf_data` into the shift register; `SPI_MOSI` = shift-register MSB; go to SHIFT.
  - **SHIFT**: each bit is SCLK low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles. The Zynq samples on the rising edge. The shift register advances and `SPI_MOSI` updates on the falling edge. After `WORD_W` bits:
    - if more words remain, go to NEXT;
    - otherwise go to DONE.
  - **NEXT**: advance addr (when it wraps to 0, increment chn); assert `buf_rd_req`; go to FETCH. `SPI_SCLK` stays low throughout.
  - **DONE**: drive `SPI_CS_N` high, pulse `SPI_complete` for 1 cycle, increment `frame_cnt` (8-bit, wraps 255→0); go to IDLE.
- Word order: chn 0 addr 0..W-1, then chn 1, …, up to chn NUM_CHN-1.
- Abort: if `ZYNQ_RD_EN` is sampled low in any state other than IDLE or DONE, then on the next edge:
  - `SPI_CS_N`=1, `SPI_SCLK`=0, return to IDLE;
  - no `SPI_complete` pulse, and `frame_cnt` is unchanged.
- Asynchronous reset mid-frame forces all reset values immediately.

## Timing
- The start edge is sampled at edge 0. At edge 1, `buf_rd_req`=1 and `SPI_CS_N`=0.
- `buf_data` is captured at edge 3; the first SCLK rise is `SCLK_DIV` cycles after that capture.
- Word cost: 2·`SCLK_DIV`·`WORD_W` cycles of shifting, plus a 3-cycle fetch gap (SCLK low).
- `SPI_complete` rises on the same edge as `SPI_CS_N` deasserts.
- The readout controller drops `ZYNQ_RD_EN` on the edge after it sees `SPI_complete`; that falling edge must not cause a restart.

## Configuration
- `SPI_RD_HDR_EN` defined:
  - before each channel's first sample, shift one header word `{4'hA, chn[3:0], frame_cnt[7:0]}` in the upper 16 bits, with the remaining lower bits zero;
  - the header is not fetched from the buffer, so it needs no FETCH gap; it costs one extra word time;
  - frame length = `NUM_CHN`·(`WORDS_PER_CHN`+1) words.
- `SPI_RD_HDR_EN` undefined: no header; frame = `NUM_CHN`·`WORDS_PER_CHN` words.

## Structure
- Shared package `spi_readout_pkg` holds:
  - the state enumeration (IDLE, FETCH, LOAD, SHIFT, NEXT, DONE, HDR);
  - the constant `HDR_MARKER` = 4'hA;
  - the `frame_cnt` width constant (8).
- Sub-module `spi_sclk_gen`: a `SCLK_DIV` divider with enable. It outputs the SCLK level plus one-cycle `rise_tick`/`fall_tick` strobes, and clears to its low phase whenever enable is low.

## Test plan
- NUM_CHN=2, WORDS=2, WORD_W=16, DIV=2, buffer word = {chn, addr, 0xA5} (header off):
  - exactly 64 SCLK rises;
  - MOSI bit stream reproduces words 0x00A5, 0x01A5, 0x10A5, 0x11A5;
  - one `SPI_complete` pulse, coincident with the `SPI_CS_N` rise.
- `ZYNQ_RD_EN` held high for 500 cycles after `SPI_complete` → no second frame; `SPI_CS_N` stays 1.
- `ZYNQ_RD_EN` dropped after the 20th SCLK rise → next cycle `SPI_CS_N`=1 and SCLK=0; no `SPI_complete`.
  - A new rising edge then starts a full frame from chn 0, addr 0.
- `reset` asserted mid-word → all outputs at reset values immediately, with no clk edge needed.
- `SPI_RD_HDR_EN`, 3 frames → third frame's chn 1 header reads 0xA102 (lower bits zero); 3 words per channel per frame.
- DIV=1, WORD_W=16, with `buf_rd_req` timing checked → each data word read exactly once, with a 1-cycle read latency.
